// File: rtl/rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_pkg : shared types for the round-robin arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_find_first.sv
// ----------------------------------------------------------------------------
// rr_find_first : first set request at or after a start position, wrapping
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_find_first
  import rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 16,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  // Modular add; operands are always below NUM_REQ so one subtraction suffices.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
    return s[IDX_W-1:0];
  endfunction

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   first;

  always_comb begin
    rot     = '0;
    first   = '0;
    found_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req_i[wrap_add(start_i, IDX_W'(i))];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_o && rot[i]) begin
        found_o = 1'b1;
        first   = IDX_W'(i);
      end
    end
    idx_o = wrap_add(start_i, first);
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter with held grants over valid/ready.
// Optional RR_ARBITER_BYPASS_EN: 0-cycle grant from IDLE.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 16,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic [NUM_REQ-1:0] gnt_onehot_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] onehot_q, onehot_d;
  logic               valid_q, valid_d;

  logic [IDX_W-1:0]   ptr_after_gnt;
  logic [IDX_W-1:0]   search_start;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;

  assign ptr_after_gnt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  // In GRANT the only search that matters is the one after acceptance.
  assign search_start  = (state_q == ARB_GRANT) ? ptr_after_gnt : ptr_q;
  assign win_onehot    = NUM_REQ'(1) << win_idx;

  rr_find_first #(
    .NUM_REQ (NUM_REQ)
  ) u_find (
    .req_i   (req_i),
    .start_i (search_start),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_found) begin
`ifdef RR_ARBITER_BYPASS_EN
          if (gnt_ready_i) begin
            ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            idx_d = win_idx;
          end else begin
            state_d  = ARB_GRANT;
            idx_d    = win_idx;
            onehot_d = win_onehot;
            valid_d  = 1'b1;
          end
`else
          state_d  = ARB_GRANT;
          idx_d    = win_idx;
          onehot_d = win_onehot;
          valid_d  = 1'b1;
`endif
        end
      end
      ARB_GRANT: begin
        if (gnt_ready_i) begin
          ptr_d = ptr_after_gnt;
          if (win_found) begin
            idx_d    = win_idx;
            onehot_d = win_onehot;
          end else begin
            state_d  = ARB_IDLE;
            onehot_d = '0;
            valid_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

`ifdef RR_ARBITER_BYPASS_EN
  logic idle_bypass;
  assign idle_bypass  = (state_q == ARB_IDLE);
  assign gnt_valid_o  = idle_bypass ? win_found : valid_q;
  assign gnt_idx_o    = (idle_bypass && win_found) ? win_idx : idx_q;
  assign gnt_onehot_o = idle_bypass ? (win_found ? win_onehot : '0) : onehot_q;
`else
  assign gnt_valid_o  = valid_q;
  assign gnt_idx_o    = idx_q;
  assign gnt_onehot_o = onehot_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NUM_REQ=16 and NUM_REQ=5).
`default_nettype none

module tb_rr_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [15:0] req;
  logic        ready;
  logic        valid;
  logic [3:0]  idx;
  logic [15:0] onehot;

  logic [4:0]  req5;
  logic        ready5;
  logic        valid5;
  logic [2:0]  idx5;
  logic [4:0]  onehot5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(16)) u_dut (
    .clk_i        (clk),
    .arst_ni      (arst_n),
    .req_i        (req),
    .gnt_valid_o  (valid),
    .gnt_ready_i  (ready),
    .gnt_idx_o    (idx),
    .gnt_onehot_o (onehot)
  );

  rr_arbiter #(.NUM_REQ(5)) u_dut5 (
    .clk_i        (clk),
    .arst_ni      (arst_n),
    .req_i        (req5),
    .gnt_valid_o  (valid5),
    .gnt_ready_i  (ready5),
    .gnt_idx_o    (idx5),
    .gnt_onehot_o (onehot5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int k);
    check({tag, "_valid"},  32'(valid),  32'd1);
    check({tag, "_idx"},    32'(idx),    32'(k));
    check({tag, "_onehot"}, 32'(onehot), 32'd1 << k);
  endtask

  initial begin
    arst_n = 1'b0;
    req    = 16'hFFFF;
    ready  = 1'b0;
    req5   = '0;
    ready5 = 1'b0;
    repeat (3) tick();
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_onehot", 32'(onehot), 32'd0);
    check("rst_idx",    32'(idx),    32'd0);
    check("rst_valid5", 32'(valid5), 32'd0);
    arst_n = 1'b1;

`ifdef RR_ARBITER_BYPASS_EN
    // Bypass: combinational grant from IDLE
    req   = 16'h0000;
    tick();
    req   = 16'h0008;
    ready = 1'b1;
    #1;
    expect_grant("byp_same_cycle", 3);
    tick();
    req = 16'h0018;
    #1;
    expect_grant("byp_ptr4", 4);
    tick();
    req   = 16'h0008;
    ready = 1'b0;
    #1;
    expect_grant("byp_noready", 3);
    tick();
    req = 16'h0000;
    #1;
    expect_grant("byp_held", 3);
    ready = 1'b1;
    tick();
    check("byp_drain_valid", 32'(valid), 32'd0);
`else
    tick();
    expect_grant("first", 0);

    // Back-to-back rotation through all requesters and wrap to 0
    ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      expect_grant("rot", k % 16);
    end

    // Drain to IDLE; index keeps its last value
    req = 16'h0000;
    tick();
    check("idle_valid",  32'(valid),  32'd0);
    check("idle_onehot", 32'(onehot), 32'd0);
    check("idle_idx",    32'(idx),    32'd0);

    // Hold: grant stays put while not ready, even if req changes
    ready = 1'b0;
    req   = 16'h0090;
    tick();
    expect_grant("hold_first", 4);
    req = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_grant("hold", 4);
    end
    ready = 1'b1;
    tick();
    expect_grant("hold_next", 8);

    // Search after idx 8 wraps past the end to bit 1
    req = 16'h0002;
    tick();
    expect_grant("wrap_single", 1);
    req = 16'h0000;
    tick();
    check("drain_valid",  32'(valid),  32'd0);
    check("drain_onehot", 32'(onehot), 32'd0);
    check("drain_idx",    32'(idx),    32'd1);
    tick();
    check("drain_stay_idle", 32'(valid), 32'd0);

    // Mid-grant asynchronous reset
    ready = 1'b0;
    req   = 16'h0001;
    tick();
    expect_grant("pre_arst", 0);
    #2 arst_n = 1'b0;
    #1;
    check("arst_valid",  32'(valid),  32'd0);
    check("arst_onehot", 32'(onehot), 32'd0);
    tick();
    arst_n = 1'b1;
    req    = 16'h0004;
    tick();
    expect_grant("post_arst", 2);

    // NUM_REQ=5: reach ptr=3, then skip-and-wrap to 0, then ptr=1 gives 2
    req5 = 5'b00100;
    tick();
    check("n5_first_idx", 32'(idx5), 32'd2);
    check("n5_first_val", 32'(valid5), 32'd1);
    ready5 = 1'b1;
    req5   = 5'b00101;
    tick();
    check("n5_wrap_idx",    32'(idx5),    32'd0);
    check("n5_wrap_onehot", 32'(onehot5), 32'h01);
    tick();
    check("n5_skip_idx",    32'(idx5),    32'd2);
    check("n5_skip_onehot", 32'(onehot5), 32'h04);
    tick();
    check("n5_again_idx", 32'(idx5), 32'd0);
    req5 = 5'b10000;
    tick();
    check("n5_top_idx", 32'(idx5), 32'd4);
    req5 = 5'b00001;
    tick();
    check("n5_after_top_idx", 32'(idx5), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
